// File: rtl/energy_detect_controller.sv
// Carrier-detect sequencer fed by the saturated window-energy stream.
// Settles the moving window, applies hold/release hysteresis and reports burst durations.
//
// state  | meaning
// IDLE   | disabled; samples drained and ignored
// SETTLE | discarding the first LENGTH samples while the window fills
// SEARCH | carrier absent; counting consecutive above-threshold samples
// ACTIVE | carrier present; counting duration and consecutive low samples
module energy_detect_controller #(
  parameter int WIDTH     = 32,
  parameter int LENGTH    = 16,
  parameter int HOLD      = 4,
  parameter int RELEASE   = 8,
  parameter int DUR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     threshold,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 detect,
  output logic                 overflow,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DUR_WIDTH-1:0] m_data
);

  localparam int RUN_MAX = (HOLD > RELEASE) ? HOLD : RELEASE;
  localparam int RW      = $clog2(RUN_MAX + 1);
  localparam int SW      = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEARCH = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t               r_state;
  logic [SW-1:0]        r_settle_cnt;
  logic [RW-1:0]        r_run_cnt;
  logic [DUR_WIDTH-1:0] r_dur_cnt;
  logic                 r_s_ready;
  logic                 r_detect;
  logic                 r_overflow;
  logic                 r_m_valid;
  logic [DUR_WIDTH-1:0] r_m_data;

  logic                 w_accept;
  logic                 w_above;
  logic                 w_can_load;
  logic [RW-1:0]        w_run_inc;
  logic [DUR_WIDTH-1:0] w_dur_inc;

  always_comb begin
    w_accept   = s_valid && r_s_ready;
    w_above    = s_data > threshold;
    w_can_load = !r_m_valid || m_ready;
    w_run_inc  = r_run_cnt + 1'b1;
    // duration saturates rather than wrapping on very long bursts
    w_dur_inc  = (r_dur_cnt == {DUR_WIDTH{1'b1}}) ? r_dur_cnt : r_dur_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_run_cnt    <= '0;
      r_dur_cnt    <= '0;
      r_s_ready    <= 1'b0;
      r_detect     <= 1'b0;
      r_overflow   <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
    end else begin
      r_s_ready <= 1'b1;
      if (r_m_valid && m_ready) r_m_valid <= 1'b0;

      if (r_state != ST_IDLE && !enable) begin
        // abort: any burst in progress is discarded, a pending report survives
        r_state      <= ST_IDLE;
        r_detect     <= 1'b0;
        r_settle_cnt <= '0;
        r_run_cnt    <= '0;
        r_dur_cnt    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (enable) begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= '0;
              r_run_cnt    <= '0;
              r_dur_cnt    <= '0;
            end
          end
          ST_SETTLE: begin
            if (w_accept) begin
              if (r_settle_cnt == SW'(LENGTH - 1)) begin
                r_state      <= ST_SEARCH;
                r_settle_cnt <= '0;
                r_run_cnt    <= '0;
              end else begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
              end
            end
          end
          ST_SEARCH: begin
            if (w_accept) begin
              if (w_above) begin
                if (w_run_inc == RW'(HOLD)) begin
                  r_state   <= ST_ACTIVE;
                  r_detect  <= 1'b1;
                  r_run_cnt <= '0;
                  r_dur_cnt <= DUR_WIDTH'(HOLD);
                end else begin
                  r_run_cnt <= w_run_inc;
                  r_dur_cnt <= DUR_WIDTH'(w_run_inc);
                end
              end else begin
                r_run_cnt <= '0;
              end
            end
          end
          ST_ACTIVE: begin
            if (w_accept) begin
              r_dur_cnt <= w_dur_inc;
              if (!w_above) begin
                if (w_run_inc == RW'(RELEASE)) begin
                  r_state   <= ST_SEARCH;
                  r_detect  <= 1'b0;
                  r_run_cnt <= '0;
                  if (w_can_load) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= w_dur_inc;
                  end else begin
                    r_overflow <= 1'b1;
                  end
                end else begin
                  r_run_cnt <= w_run_inc;
                end
              end else begin
                r_run_cnt <= '0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_ready  = r_s_ready;
  assign detect   = r_detect;
  assign overflow = r_overflow;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;

endmodule

// File: tb/tb_energy_detect_controller.sv
// Directed bench for energy_detect_controller: settle, hysteresis, report buffering, abort.
module tb_energy_detect_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] threshold;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        detect;
  logic        overflow;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic saw_detect;
  logic saw_valid;

  always #5 clk = ~clk;

  energy_detect_controller #(
    .WIDTH(32), .LENGTH(16), .HOLD(4), .RELEASE(8), .DUR_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .detect(detect), .overflow(overflow),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // present one sample for one cycle; returns on the next negedge
  task automatic send(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      send(d);
      if (detect) saw_detect = 1'b1;
      if (m_valid) saw_valid = 1'b1;
    end
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; threshold = 32'd1000;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    saw_detect = 1'b0; saw_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_detect", detect, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("s_ready_out_of_reset", s_ready, 1);

    // settle plus a short above run broken by a low sample
    enable = 1'b1;
    @(negedge clk);
    send_n(16, 32'd5000);
    send_n(3, 32'd5000);
    send_n(1, 32'd10);
    chk("settle_no_detect", saw_detect, 0);
    chk("s_ready_running", s_ready, 1);

    // basic burst: 4 hold + 10 + 8 release = 22
    send_n(3, 32'd2000);
    chk("hold_3_no_detect", detect, 0);
    send(32'd2000);
    chk("hold_4_detect", detect, 1);
    send_n(10, 32'd2000);
    send_n(7, 32'd10);
    chk("release_7_still", detect, 1);
    send(32'd10);
    chk("release_8_drop", detect, 0);
    chk("burst1_m_valid", m_valid, 1);
    chk("burst1_m_data", m_data, 22);
    handshake();
    chk("burst1_m_valid_clr", m_valid, 0);

    // broken release run: 4 + 7 + 1 + 8 = 20
    send_n(4, 32'd2000);
    chk("burst2_detect", detect, 1);
    send_n(7, 32'd10);
    send(32'd2000);
    chk("burst2_low_run_broken", detect, 1);
    send_n(7, 32'd10);
    chk("burst2_release_7", detect, 1);
    send(32'd10);
    chk("burst2_release_8", detect, 0);
    chk("burst2_m_valid", m_valid, 1);
    chk("burst2_m_data", m_data, 20);
    handshake();

    // backpressure: first report (12) held, second (14) dropped
    send_n(4, 32'd2000);
    send_n(8, 32'd10);
    chk("bp_first_valid", m_valid, 1);
    chk("bp_first_data", m_data, 12);
    chk("bp_no_overflow_yet", overflow, 0);
    send_n(6, 32'd3000);
    chk("bp_held_midburst", m_data, 12);
    send_n(8, 32'd10);
    chk("bp_held_after_drop", m_data, 12);
    chk("bp_overflow", overflow, 1);
    handshake();
    chk("bp_valid_clr", m_valid, 0);
    @(negedge clk);
    chk("bp_overflow_sticky", overflow, 1);

    // equality is not above threshold; gaps between samples
    saw_detect = 1'b0; saw_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      send_n(1, 32'd1000);
      @(negedge clk);
      if (detect) saw_detect = 1'b1;
    end
    chk("equal_no_detect", saw_detect, 0);
    chk("equal_no_report", saw_valid, 0);

    // abort mid-burst, then resettle
    send_n(4, 32'd2000);
    chk("abort_active", detect, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_detect_low", detect, 0);
    send_n(8, 32'd10);
    chk("abort_no_report", m_valid, 0);
    enable = 1'b1;
    @(negedge clk);
    saw_detect = 1'b0; saw_valid = 1'b0;
    send_n(15, 32'd5000);
    chk("resettle_15_no_detect", saw_detect, 0);
    send_n(4, 32'd5000);
    chk("resettle_19_no_detect", saw_detect, 0);
    send(32'd5000);
    chk("resettle_20_detect", detect, 1);
    chk("resettle_no_report", saw_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/energy_detect_controller.md
Name: energy_detect_controller

Overview:
- Sequencing controller downstream of the window-energy datapath (complex magnitude squared -> moving sum -> saturate).
- Consumes the saturated energy stream and discards the first LENGTH samples after enable while the moving window fills.
- Declares carrier detect with hold/release hysteresis against a programmable threshold.
- Emits one burst-duration report per detected burst on an output valid/ready stream.

Parameters:
- WIDTH, 32: energy sample width in bits; matches window energy m_data.
- LENGTH, 16: number of settle samples discarded after enable; equals the moving-sum window length.
- HOLD, 4: consecutive above-threshold samples required to assert detect; must be >= 1.
- RELEASE, 8: consecutive at-or-below-threshold samples required to deassert detect; must be >= 1.
- DUR_WIDTH, 16: width of the duration report.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  controller enable; level-sensitive.
- threshold  in  WIDTH  detect threshold, unsigned.
- s_valid  in  1  energy sample valid.
- s_ready  out  1  energy sample ready.
- s_data  in  WIDTH  energy sample, unsigned.
- detect  out  1  carrier-detect level.
- overflow  out  1  sticky flag: a report was dropped.
- m_valid  out  1  duration report valid.
- m_ready  in  1  duration report ready.
- m_data  out  DUR_WIDTH  burst duration in accepted samples.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; all counters cleared.
  - s_ready=0, detect=0, overflow=0, m_valid=0, m_data=0.
- s_ready=1 in every state when out of reset, including IDLE, so samples are drained. A sample is accepted on clk when s_valid && s_ready.
- Above-threshold means s_data > threshold (strict). Equality counts as below.
- threshold is sampled on each accepted sample; a change applies to the next accepted sample.
- States and transitions; all evaluate on accepted samples except enable, which acts on any clock:
  - IDLE: accepted samples are ignored. enable==1 -> SETTLE with settle_cnt=0.
  - SETTLE: each accepted sample increments settle_cnt. After the LENGTH-th accepted sample -> SEARCH with run_cnt=0. No threshold comparison during SETTLE.
  - SEARCH:
    - Above-threshold sample: run_cnt++; dur_cnt = run_cnt after the increment.
    - Below-threshold sample: run_cnt=0.
    - When run_cnt reaches HOLD: -> ACTIVE. detect=1 registered, visible the cycle after the HOLD-th sample is accepted. run_cnt=0.
  - ACTIVE:
    - Every accepted sample: dur_cnt++, saturating at 2^DUR_WIDTH-1.
    - Below-threshold sample: run_cnt++. Above-threshold sample: run_cnt=0.
    - When run_cnt reaches RELEASE: -> SEARCH. detect=0 the following cycle. A report is issued with m_data = dur_cnt, which includes the hold run and the release run.
- enable==0 in any non-IDLE state: -> IDLE next cycle; detect=0; counters cleared.
  - An in-progress burst is aborted and produces no report.
  - A pending report (m_valid==1) is kept.
- Report buffer is a single entry:
  - On issue with m_valid==0: m_valid=1, m_data loaded.
  - While m_valid==1 and !m_ready: m_data is held stable.
  - m_valid && m_ready: m_valid=0 the next cycle.
  - Issue coinciding with m_valid && m_ready: new report loaded, m_valid stays 1.
  - Issue while m_valid && !m_ready: new report dropped, overflow=1.
- overflow is cleared only by reset.
- Latency: detect edges and m_valid rise occur 1 cycle after the qualifying sample is accepted.
- Gaps in s_valid do not reset run_cnt or dur_cnt; counts are in accepted samples, not cycles.

Test Plan (LENGTH=16, HOLD=4, RELEASE=8, threshold=1000):
- Reset low 3 cycles, then enable=1; 16 samples of 5000, then 3x5000, then 1x10 -> detect stays 0 throughout; s_ready=0 during reset and 1 after.
- After settle: 4x2000 -> detect=1 one cycle after the 4th is accepted. Then 10x2000, then 8x10 -> detect=0 one cycle after the 8th low sample; m_valid=1 with m_data=22.
- In ACTIVE: 7x10, 1x2000, 8x10 -> detect stays 1 until the final low sample; a single report with duration = hold + 16 + prior active samples.
- m_ready=0, two complete bursts -> first m_data held stable, second dropped, overflow=1. Then m_ready=1 -> one handshake, m_valid=0 next cycle.
- Settled, 50 samples exactly 1000 with s_valid toggling -> detect never asserts; no report.
- In ACTIVE, drop enable -> detect=0 next cycle; no report. Re-enable and give 15 samples of 5000 -> no detect; samples 16-20 of 5000 -> detect=1 after the 20th.
